pool_ctrl: RTL

Window sequencer and result buffer wrapped around the max-pool stage. It accepts the element stream with a valid/ready handshake and forwards each element to the pool stage. It pulses the pool restart on the first element of every window, then captures the pool result a fixed latency after each window's last element. Captured results are emitted on a valid/ready stream to the next layer stage. Credit-based throttling guarantees that no pool result is overwritten before it is captured.

---
 rtl/pool_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pool_ctrl.sv
// pool_ctrl: window sequencer and result buffer around the max-pool stage.
// Elements pass straight through to the pool stage; the first element of each
// window carries pool_restart, and the held pool result is captured POOL_LAT
// cycles after the window's last element into a small FIFO that feeds the
// downstream stream. One credit per FIFO slot is taken at window start and
// given back on pop, so a capture can never find the FIFO full.
// POOL_LAT must be at least 1; DEPTH must be at least 1.
module pool_ctrl #(
  parameter int NUM_WIDTH  = 16,
  parameter int SIZE_WIDTH = 8,
  parameter int POOL_LAT   = 4,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SIZE_WIDTH-1:0] cfg_size,
  input  logic [NUM_WIDTH-1:0]  up_data,
  input  logic                  up_valid,
  output logic                  up_ready,
  output logic                  pool_restart,
  output logic [NUM_WIDTH-1:0]  pool_data,
  output logic                  pool_valid,
  input  logic [NUM_WIDTH-1:0]  pool_result,
  output logic [NUM_WIDTH-1:0]  dn_data,
  output logic                  dn_valid,
  input  logic                  dn_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SIZE_WIDTH-1:0] count_q, count_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [SIZE_WIDTH-1:0] cfg_eff;
  logic [CW-1:0]         credits_q, credits_d;
  logic [CW-1:0]         occ_q, occ_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [POOL_LAT-1:0]   last_sr_q, last_sr_d;
  logic [NUM_WIDTH-1:0]  mem_q [DEPTH];

  logic first, accept, last, push, pop, full;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake and pool-stage drive. Ready depends only on state (and reset),
  // never on up_valid, and only ever stalls between windows.
  assign first        = (count_q == '0);
  assign cfg_eff      = (cfg_size == '0) ? SIZE_WIDTH'(1) : cfg_size;
  assign up_ready     = rst_n & (!first | (credits_q != '0));
  assign accept       = up_valid & up_ready;
  assign pool_valid   = accept;
  assign pool_data    = rst_n ? up_data : '0;
  assign pool_restart = accept & first;

  // Together with the live last flag, last_sr_q forms the POOL_LAT+1 tap delay
  // line; its oldest tap lines up with pool_result settling on the window max.
  assign push     = last_sr_q[POOL_LAT-1];
  assign dn_valid = (occ_q != '0);
  assign pop      = dn_valid & dn_ready;
  assign full     = (occ_q == CW'(DEPTH));
  assign dn_data  = mem_q[rd_ptr_q];

  // Window counter, credit and FIFO bookkeeping for the next cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    count_d   = count_q;
    size_d    = size_q;
    last      = 1'b0;
    if (accept) begin
      if (first) begin
        size_d = cfg_eff;
        last   = (cfg_eff == SIZE_WIDTH'(1));
      end else begin
        last   = (count_q == size_q - SIZE_WIDTH'(1));
      end
      count_d = last ? '0 : count_q + SIZE_WIDTH'(1);
    end
    last_sr_d = POOL_LAT'({last_sr_q, last});
    credits_d = credits_q + CW'(pop) - CW'(pool_restart);
    occ_d     = occ_q + CW'(push) - CW'(pop);
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  // State registers; reset discards every in-flight window and buffered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state uses non-blocking assignments so all registers update together at the edge.
      count_q   <= '0;
      size_q    <= SIZE_WIDTH'(1);
      credits_q <= CW'(DEPTH);
      occ_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      last_sr_q <= '0;
    end else begin
      count_q   <= count_d;
      size_q    <= size_d;
      credits_q <= credits_d;
      occ_q     <= occ_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      last_sr_q <= last_sr_d;
    end
  end

  // Result storage, written on the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this memory is reset on purpose so dn_data reads 0 out of reset; only worth it because it is tiny.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= pool_result;
    end
  end

  // A capture into a full FIFO would lose a result; credits make it unreachable.
  a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_credit_range : assert property (@(posedge clk) disable iff (!rst_n) credits_q <= CW'(DEPTH));

endmodule
